// File: rtl/pipe_stage_reg_pkg.sv
// pipe_stage_reg_pkg: shared pipeline constants (PC init, NOP) and the stage state encoding
package pipe_stage_reg_pkg;

    localparam logic [31:0] PC_INIT = 32'hBFC0_0000;
    localparam logic [31:0] NOP     = 32'h0000_0000;

    // The encoding doubles as the occupancy count reported on occ.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

endpackage

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic pipeline boundary register (1- or 2-entry) with valid/ready, flush and NOP bubbles
//   cpu_clk_50M, cpu_rst        : clock, async active-high reset
//   flush                       : synchronous discard of all held entries
//   in_valid/in_ready/in_pc/in_data     : upstream handshake and entry
//   out_valid/out_ready/out_pc/out_data : downstream handshake and entry (from main only)
//   occ                         : number of held entries (0..2)
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int                PC_W     = 32,
    parameter int                DATA_W   = 32,
    parameter logic [PC_W-1:0]   PC_RST   = PC_W'(PC_INIT),
    parameter logic [DATA_W-1:0] DATA_RST = DATA_W'(NOP),
    parameter bit                SKID     = 1'b1
) (
    input  logic              cpu_clk_50M,
    input  logic              cpu_rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occ
);

    state_t              state, state_nx;
    logic                rdy_q;
    logic                acc, con, load_main, load_skid;
    logic [PC_W-1:0]     main_pc, skid_pc;
    logic [DATA_W-1:0]   main_data, skid_data;

    assign acc = in_valid && in_ready;
    assign con = out_valid && out_ready;

    // rdy_q is the registered in_ready when SKID=1; with SKID=0 it only
    // keeps in_ready low from reset until the first edge after release.
    always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
        if (cpu_rst) begin
            state <= ST_EMPTY;
            rdy_q <= 1'b0;
        end else begin
            state <= state_nx;
            rdy_q <= SKID ? (state_nx != ST_TWO) : 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        if (flush)
            state_nx = ST_EMPTY;
        else if (state == ST_EMPTY)
            state_nx = acc ? ST_ONE : ST_EMPTY;
        else if (state == ST_ONE)
            state_nx = con ? (acc ? ST_ONE : ST_EMPTY) : ((acc && SKID) ? ST_TWO : ST_ONE);
        else
            state_nx = con ? ST_ONE : ST_TWO;
    end

    always_comb begin
        out_valid = state != ST_EMPTY;
        in_ready  = SKID ? rdy_q : rdy_q && ((state == ST_EMPTY) || out_ready);
        out_pc    = out_valid ? main_pc : PC_RST;
        out_data  = out_valid ? main_data : DATA_RST;
        occ       = state;
    end

    // Main refills from the input when it empties or drains this cycle,
    // or from skid when the stage holds two entries and one leaves.
    assign load_main = !flush && (((state == ST_EMPTY) && acc)
                               || ((state == ST_ONE) && acc && con)
                               || ((state == ST_TWO) && con));
    assign load_skid = !flush && SKID && (state == ST_ONE) && acc && !con;

    always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
        if (cpu_rst) begin
            main_pc   <= PC_RST;
            main_data <= DATA_RST;
            skid_pc   <= '0;
            skid_data <= '0;
        end else begin
            if (load_main) begin
                main_pc   <= (state == ST_TWO) ? skid_pc : in_pc;
                main_data <= (state == ST_TWO) ? skid_data : in_data;
            end
            if (load_skid) begin
                skid_pc   <= in_pc;
                skid_data <= in_data;
            end
        end
    end

endmodule
